// File: rtl/jtag_id_usercode_register_if.sv
// rtl/jtag_id_usercode_register_if.sv - TAP-side signal bundle for the ID/USERCODE data register
//
// Purpose: groups the TAP strobes, instruction selects, serial data and the
// USERCODE outputs of one jtag_id_usercode_register instance.
// Modports:
//   master - TAP controller / instruction decoder side (drives tdi, strobes, selects)
//   slave  - data register side (drives tdo, usercode, update_reject)
interface jtag_id_usercode_register_if #(
    parameter int WIDTH = 32
);
    logic             tdi;
    logic             captureDR;
    logic             shiftDR;
    logic             updateDR;
    logic             select_idcode;
    logic             select_usercode;
    logic             tdo;
    logic [WIDTH-1:0] usercode;
    logic             update_reject;

    modport master (
        output tdi, captureDR, shiftDR, updateDR, select_idcode, select_usercode,
        input  tdo, usercode, update_reject
    );

    modport slave (
        input  tdi, captureDR, shiftDR, updateDR, select_idcode, select_usercode,
        output tdo, usercode, update_reject
    );
endinterface

// File: rtl/jtag_id_usercode_register.sv
// rtl/jtag_id_usercode_register.sv - JTAG IDCODE/USERCODE data register with guarded update
//
// Purpose: one shift path serving IDCODE and USERCODE. Under USERCODE an
// Update-DR commits the shifted word into the USERCODE holding register, but
// only when exactly WIDTH shifts happened since the last capture.
// Ports:
//   tck   - test clock, all state changes on rising edge
//   trst  - asynchronous active-low reset
//   tap   - slave side of jtag_id_usercode_register_if:
//           tdi/captureDR/shiftDR/updateDR/select_idcode/select_usercode in,
//           tdo (shift_reg[0]), usercode, update_reject (sticky) out
module jtag_id_usercode_register #(
    parameter int               WIDTH             = 32,
    parameter logic [WIDTH-1:0] DEVICE_ID         = 32'h0000_0001,
    parameter logic [WIDTH-1:0] USERCODE_RESET    = 32'h0000_0000,
    parameter bit               USERCODE_WRITABLE = 1'b1
) (
    input  logic                          tck,
    input  logic                          trst,
    jtag_id_usercode_register_if.slave    tap
);
    if (WIDTH < 2) begin : g_bad_width
        $error("jtag_id_usercode_register: WIDTH must be at least 2");
    end
    if (DEVICE_ID[0] != 1'b1) begin : g_bad_id
        $error("jtag_id_usercode_register: DEVICE_ID bit 0 must be 1");
    end

    // Counter spans 0..WIDTH+1 so "too many shifts" is distinguishable from exactly WIDTH.
    localparam int             CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH + 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] usercode_q, usercode_d;
    logic [CNT_W-1:0] shift_cnt_q, shift_cnt_d;
    logic             update_reject_q, update_reject_d;

    always_ff @(posedge tck or negedge trst) begin
        if (!trst) begin
            shift_q         <= DEVICE_ID;
            usercode_q      <= USERCODE_RESET;
            shift_cnt_q     <= '0;
            update_reject_q <= 1'b0;
        end else begin
            shift_q         <= shift_d;
            usercode_q      <= usercode_d;
            shift_cnt_q     <= shift_cnt_d;
            update_reject_q <= update_reject_d;
        end
    end

    always_comb begin
        shift_d         = shift_q;
        usercode_d      = usercode_q;
        shift_cnt_d     = shift_cnt_q;
        update_reject_d = update_reject_q;

        if (tap.select_idcode || tap.select_usercode) begin
            if (tap.captureDR) begin
                // IDCODE wins when both selects are high.
                shift_d     = tap.select_idcode ? DEVICE_ID : usercode_q;
                shift_cnt_d = '0;
            end else if (tap.shiftDR) begin
                shift_d = {tap.tdi, shift_q[WIDTH-1:1]};
                if (shift_cnt_q != CNT_MAX) begin
                    shift_cnt_d = shift_cnt_q + 1'b1;
                end
            end else if (tap.updateDR && !tap.select_idcode && USERCODE_WRITABLE) begin
                if (shift_cnt_q == CNT_FULL) begin
                    usercode_d      = shift_q;
                    update_reject_d = 1'b0;
                end else begin
                    update_reject_d = 1'b1;
                end
            end
        end
    end

    assign tap.tdo           = shift_q[0];
    assign tap.usercode      = usercode_q;
    assign tap.update_reject = update_reject_q;

    // Every legal IDCODE begins with a 1 so the host can tell it from BYPASS.
    a_idcode_lsb: assert property (@(posedge tck) disable iff (!trst)
        (tap.captureDR && tap.select_idcode) |=> shift_q[0]);
endmodule

// File: tb/tb_jtag_id_usercode_register.sv
// tb/tb_jtag_id_usercode_register.sv - scoreboard bench for jtag_id_usercode_register
module tb_jtag_id_usercode_register;
    localparam int          W       = 32;
    localparam logic [31:0] DEV_ID  = 32'h1234_5677;
    localparam logic [31:0] UC_RST  = 32'hA5A5_3C3C;

    logic tck;
    logic trst;

    jtag_id_usercode_register_if #(.WIDTH(W)) ifa ();
    jtag_id_usercode_register_if #(.WIDTH(W)) ifb ();

    jtag_id_usercode_register #(
        .WIDTH(W), .DEVICE_ID(DEV_ID), .USERCODE_RESET(UC_RST), .USERCODE_WRITABLE(1'b1)
    ) dut_a (.tck(tck), .trst(trst), .tap(ifa));

    jtag_id_usercode_register #(
        .WIDTH(W), .DEVICE_ID(DEV_ID), .USERCODE_RESET(UC_RST), .USERCODE_WRITABLE(1'b0)
    ) dut_b (.tck(tck), .trst(trst), .tap(ifb));

    initial tck = 1'b0;
    always #5 tck = ~tck;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]  tdo;
        logic [31:0] uc_a;
        logic [31:0] uc_b;
        logic [1:0]  rej;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: index 0 is the writable instance, 1 the read-only one.
    logic [31:0] m_sr  [2];
    logic [31:0] m_uc  [2];
    int          m_n   [2];
    bit          m_rej [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_sr[k] = DEV_ID; m_uc[k] = UC_RST; m_n[k] = 0; m_rej[k] = 1'b0;
        end
    endfunction

    function automatic void model_step(input bit cap, input bit sh, input bit up,
                                       input bit d, input bit sid, input bit suc);
        for (int k = 0; k < 2; k++) begin
            if (!(sid || suc)) continue;
            if (cap) begin
                m_sr[k] = sid ? DEV_ID : m_uc[k];
                m_n[k]  = 0;
            end else if (sh) begin
                m_sr[k] = (m_sr[k] >> 1) | (32'(d) << 31);
                m_n[k]  = m_n[k] + 1;
            end else if (up && !sid && k == 0) begin
                if (m_n[k] == W) begin
                    m_uc[k] = m_sr[k]; m_rej[k] = 1'b0;
                end else begin
                    m_rej[k] = 1'b1;
                end
            end
        end
    endfunction

    function automatic void push_expect();
        exp_t e;
        e.tdo  = {m_sr[1][0], m_sr[0][0]};
        e.uc_a = m_uc[0];
        e.uc_b = m_uc[1];
        e.rej  = {m_rej[1], m_rej[0]};
        exp_q.push_back(e);
    endfunction

    task automatic drive(input bit cap, input bit sh, input bit up,
                         input bit d, input bit sid, input bit suc);
        ifa.captureDR = cap; ifa.shiftDR = sh; ifa.updateDR = up;
        ifa.tdi = d; ifa.select_idcode = sid; ifa.select_usercode = suc;
        ifb.captureDR = cap; ifb.shiftDR = sh; ifb.updateDR = up;
        ifb.tdi = d; ifb.select_idcode = sid; ifb.select_usercode = suc;
    endtask

    task automatic cyc(input bit cap, input bit sh, input bit up,
                       input bit d, input bit sid, input bit suc);
        @(negedge tck);
        drive(cap, sh, up, d, sid, suc);
        @(posedge tck);
        model_step(cap, sh, up, d, sid, suc);
        push_expect();
    endtask

    task automatic do_reset();
        @(negedge tck);
        #3 trst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #1 push_expect();
        @(negedge tck);
        #3 trst = 1'b1;
    endtask

    task automatic shift_word(input logic [31:0] v, input int n, input bit sid, input bit suc);
        for (int i = 0; i < n; i++) cyc(0, 1, 0, v[i % 32], sid, suc);
    endtask

    task automatic uc_write(input logic [31:0] v, input int n);
        cyc(1, 0, 0, 0, 0, 1);
        shift_word(v, n, 0, 1);
        cyc(0, 0, 1, 0, 0, 1);
        #1;
    endtask

    // Monitor: compares both instances against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge tck);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tdo_a", 32'(ifa.tdo), 32'(e.tdo[0]));
                check("tdo_b", 32'(ifb.tdo), 32'(e.tdo[1]));
                check("usercode_a", ifa.usercode, e.uc_a);
                check("usercode_b", ifb.usercode, e.uc_b);
                check("reject_a", 32'(ifa.update_reject), 32'(e.rej[0]));
                check("reject_b", 32'(ifb.update_reject), 32'(e.rej[1]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int          n;
        bit          sid, suc;
        trst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();

        do_reset();
        check("tdo_after_reset", 32'(ifa.tdo), 32'd1);

        // IDCODE readout
        cyc(1, 0, 0, 0, 1, 0);
        shift_word($urandom(), 32, 1, 0);

        // Good USERCODE write, then read it back
        uc_write(32'hCAFE_F00D, 32);
        check("usercode_written", ifa.usercode, 32'hCAFE_F00D);
        check("reject_clear", 32'(ifa.update_reject), 32'd0);
        cyc(1, 0, 0, 0, 0, 1);
        shift_word($urandom(), 32, 0, 1);

        // Read-only instance sees all-ones write
        uc_write(32'hFFFF_FFFF, 32);
        check("ro_usercode", ifb.usercode, UC_RST);
        check("ro_reject", 32'(ifb.update_reject), 32'd0);

        // Wrong shift lengths are rejected
        do_reset();
        uc_write(32'h1357_9BDF, 31);
        check("short_usercode", ifa.usercode, UC_RST);
        check("short_reject", 32'(ifa.update_reject), 32'd1);
        uc_write(32'h2468_ACE0, 33);
        check("long_usercode", ifa.usercode, UC_RST);
        check("long_reject", 32'(ifa.update_reject), 32'd1);
        uc_write(32'h0BAD_CAFE, 32);
        check("rewrite_reject", 32'(ifa.update_reject), 32'd0);

        // Both selects, and capture with shift in the same cycle
        cyc(1, 0, 0, 0, 1, 1);
        cyc(0, 1, 0, 1, 1, 1);
        cyc(1, 1, 0, 0, 0, 1);
        cyc(1, 1, 1, 1, 1, 0);

        // Reset mid-shift, then capture-less update
        cyc(1, 0, 0, 0, 0, 1);
        shift_word(32'hDEAD_BEEF, 10, 0, 1);
        do_reset();
        cyc(0, 0, 1, 0, 0, 1);
        #1;
        check("abort_usercode", ifa.usercode, UC_RST);
        check("abort_reject", 32'(ifa.update_reject), 32'd1);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 9))
                0: do_reset();
                7, 8, 9: begin
                    for (int c = 0; c < 8; c++)
                        cyc(1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                            1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom));
                end
                default: begin
                    sid = ($urandom_range(0, 4) == 0);
                    suc = ($urandom_range(0, 5) != 0);
                    case ($urandom_range(0, 5))
                        0:       n = 31;
                        1:       n = 33;
                        2:       n = $urandom_range(0, 40);
                        default: n = 32;
                    endcase
                    v = $urandom();
                    if ($urandom_range(0, 7) != 0) cyc(1, 0, 0, 0, sid, suc);
                    shift_word(v, n, sid, suc);
                    cyc(0, 0, 1, 0, sid, suc);
                end
            endcase
        end

        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge tck);
        @(posedge tck);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
